// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg -- shared binary32 field definitions for the FPU datapath.
//   EXP_W / MAN_W   : exponent and mantissa field widths
//   EXP_MAX         : all-ones exponent (infinity / NaN encoding)
//   QNAN_DEFAULT    : quiet NaN returned for +inf + -inf
//   fp32_t          : packed sign / exponent / mantissa view of a word
//   is_nan / is_inf : classification helpers
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;

    localparam logic [EXP_W-1:0] EXP_MAX      = 8'hFF;
    localparam logic [31:0]      QNAN_DEFAULT = 32'hFFC00000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp32_t;

    function automatic logic is_nan(input fp32_t f);
        return (f.exp == EXP_MAX) && (f.man != 23'h0);
    endfunction

    function automatic logic is_inf(input fp32_t f);
        return (f.exp == EXP_MAX) && (f.man == 23'h0);
    endfunction

endpackage

// File: rtl/fadd_if.sv
// ---------------------------------------------------------------------------
// fadd_if -- operand / result bundle of the binary32 adder.
//   x1, x2 : operands (master drives)
//   y, ovf : registered sum and overflow flag (slave drives)
// ---------------------------------------------------------------------------
interface fadd_if;

    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
    logic        ovf;

    modport master (output x1, output x2, input  y, input  ovf);
    modport slave  (input  x1, input  x2, output y, output ovf);

endinterface

// File: rtl/fadd_lzc.sv
// ---------------------------------------------------------------------------
// fadd_lzc -- 28-bit leading-zero counter for post-subtraction normalization.
//   d   : value to scan (bit 27 is the most significant)
//   cnt : number of leading zeros, 28 when d is zero
// ---------------------------------------------------------------------------
module fadd_lzc (
    input  logic [27:0] d,
    output logic [4:0]  cnt
);

    // Scan upward so the highest set bit is the last one to update cnt
    always_comb begin
        cnt = 5'd28;
        for (int i = 0; i < 28; i++) begin
            if (d[i]) begin
                cnt = 5'(27 - i);
            end else begin
                cnt = cnt;
            end
        end
    end

endmodule

// File: rtl/fadd.sv
// ---------------------------------------------------------------------------
// fadd -- IEEE-754 binary32 adder, round-to-nearest-even, one register stage.
//   x1, x2 : operands, sampled on the rising edge of clk
//   y      : registered sum (x1 + x2)
//   ovf    : registered flag, finite operands rounded to infinity
//   clk    : clock
//   rstn   : asynchronous active-low reset, clears y and ovf
// Build option: define FADD_SUBNORMAL_EN for exact subnormal inputs and
// results; without it subnormals are treated/flushed as signed zero.
// ---------------------------------------------------------------------------
module fadd
    import fpu_pkg::*;
(
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y,
    output logic        ovf,
    input  logic        clk,
    input  logic        rstn
);

`ifdef FADD_SUBNORMAL_EN
    localparam bit SUBNORM_EN = 1'b1;
`else
    localparam bit SUBNORM_EN = 1'b0;
`endif

    fp32_t       a_s, b_s, big_s;
    logic [23:0] sig_a_s, sig_b_s, sig_big_s, sig_sml_s;
    logic [7:0]  eexp_a_s, eexp_b_s, eexp_big_s, eexp_sml_s, diff_s;
    logic        sub_s;
    logic [49:0] ext_s;
    logic [26:0] al_s, base_s, norm_s;
    logic [27:0] sum_s;
    logic [4:0]  lz28_s, lz27_s;
    logic [7:0]  lim_s, shamt_s;
    logic [8:0]  exp9_s;
    logic        inc_s, res_sign_s;
    logic [31:0] raw_s, fin_y_s, y_next_s;
    logic        fin_ovf_s, ovf_next_s;

    assign a_s = fp32_t'(x1);
    assign b_s = fp32_t'(x2);

    // Unpack, align the smaller operand, add/subtract by effective sign
    always_comb begin
        // Exponent field 0 means hidden bit 0 at effective exponent 1
        sig_a_s  = (a_s.exp != 8'h00) ? {1'b1, a_s.man}
                 : (SUBNORM_EN ? {1'b0, a_s.man} : 24'h0);
        sig_b_s  = (b_s.exp != 8'h00) ? {1'b1, b_s.man}
                 : (SUBNORM_EN ? {1'b0, b_s.man} : 24'h0);
        eexp_a_s = (a_s.exp == 8'h00) ? 8'h01 : a_s.exp;
        eexp_b_s = (b_s.exp == 8'h00) ? 8'h01 : b_s.exp;

        // On equal magnitudes x1 stays the base; zero sign is fixed later
        if ({eexp_a_s, sig_a_s} >= {eexp_b_s, sig_b_s}) begin
            big_s      = a_s;
            sig_big_s  = sig_a_s;
            eexp_big_s = eexp_a_s;
            sig_sml_s  = sig_b_s;
            eexp_sml_s = eexp_b_s;
        end else begin
            big_s      = b_s;
            sig_big_s  = sig_b_s;
            eexp_big_s = eexp_b_s;
            sig_sml_s  = sig_a_s;
            eexp_sml_s = eexp_a_s;
        end
        diff_s = eexp_big_s - eexp_sml_s;
        sub_s  = a_s.sign ^ b_s.sign;

        // Layout of 27-bit values: [26:3] significand, [2] G, [1] R, [0] S
        ext_s = {sig_sml_s, 26'h0} >> diff_s;
        if (diff_s >= 8'd26) begin
            al_s = {26'h0, |sig_sml_s};
        end else begin
            al_s = {ext_s[49:24], |ext_s[23:0]};
        end
        base_s = {sig_big_s, 3'b000};

        if (sub_s) begin
            sum_s = {1'b0, base_s} - {1'b0, al_s};
        end else begin
            sum_s = {1'b0, base_s} + {1'b0, al_s};
        end
    end

    fadd_lzc u_lzc (
        .d   (sum_s),
        .cnt (lz28_s)
    );

    // Normalize, round to nearest even, pack the finite result
    always_comb begin
        lz27_s  = lz28_s - 5'd1;
        lim_s   = eexp_big_s - 8'd1;
        shamt_s = ({3'b000, lz27_s} < lim_s) ? {3'b000, lz27_s} : lim_s;

        if (sum_s[27]) begin
            norm_s = {sum_s[27:2], sum_s[1] | sum_s[0]};
            exp9_s = {1'b0, eexp_big_s} + 9'd1;
        end else begin
            // Shift is capped at exponent 1; hidden bit still 0 means subnormal
            norm_s = sum_s[26:0] << shamt_s;
            exp9_s = norm_s[26] ? {1'b0, eexp_big_s - shamt_s} : 9'h000;
        end

        inc_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        // A carry out of the mantissa field lands in the exponent by itself
        raw_s = {exp9_s, norm_s[25:3]} + {31'h0, inc_s};

        res_sign_s = ((sum_s == 28'h0) && sub_s) ? 1'b0 : big_s.sign;

        if (raw_s[31:23] >= 9'd255) begin
            fin_y_s   = {res_sign_s, EXP_MAX, 23'h0};
            fin_ovf_s = 1'b1;
        end else if (!SUBNORM_EN && (raw_s[30:23] == 8'h00)) begin
            fin_y_s   = {res_sign_s, 31'h0};
            fin_ovf_s = 1'b0;
        end else begin
            fin_y_s   = {res_sign_s, raw_s[30:0]};
            fin_ovf_s = 1'b0;
        end
    end

    // Special operands override the arithmetic path
    always_comb begin
        if (is_nan(a_s)) begin
            y_next_s   = x1 | 32'h0040_0000;
            ovf_next_s = 1'b0;
        end else if (is_nan(b_s)) begin
            y_next_s   = x2 | 32'h0040_0000;
            ovf_next_s = 1'b0;
        end else if (is_inf(a_s) && is_inf(b_s)) begin
            y_next_s   = (a_s.sign == b_s.sign) ? x1 : QNAN_DEFAULT;
            ovf_next_s = 1'b0;
        end else if (is_inf(a_s)) begin
            y_next_s   = x1;
            ovf_next_s = 1'b0;
        end else if (is_inf(b_s)) begin
            y_next_s   = x2;
            ovf_next_s = 1'b0;
        end else begin
            y_next_s   = fin_y_s;
            ovf_next_s = fin_ovf_s;
        end
    end

    // Output register: one result per cycle, cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y   <= 32'h0;
            ovf <= 1'b0;
        end else begin
            y   <= y_next_s;
            ovf <= ovf_next_s;
        end
    end

endmodule

// File: tb/tb_fadd.sv
// ---------------------------------------------------------------------------
// tb_fadd -- self-checking bench for the binary32 adder fadd.
// Directed vectors with hand-computed results, then a back-to-back sweep
// over every exponent pair checked against a real-arithmetic reference,
// then an asynchronous mid-stream reset.
// ---------------------------------------------------------------------------
module tb_fadd;

`ifdef FADD_SUBNORMAL_EN
    localparam bit SUBNORM_EN = 1'b1;
`else
    localparam bit SUBNORM_EN = 1'b0;
`endif

    logic clk;
    logic rstn;
    int   n_cmp = 0;
    int   n_bad = 0;

    fadd_if bus ();

    fadd dut (
        .x1   (bus.x1),
        .x2   (bus.x2),
        .y    (bus.y),
        .ovf  (bus.ovf),
        .clk  (clk),
        .rstn (rstn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected summary before it");
        $fatal(1);
    end

    // binary32 word -> exact double value
    function automatic real f2r(input logic [31:0] f);
        real r;
        if (f[30:23] == 8'h00) begin
            r = real'(f[22:0]) * $bitstoreal(64'h36A0000000000000); // 2^-149
        end else begin
            r = $bitstoreal({1'b0, 11'(int'(f[30:23]) + 896), f[22:0], 29'h0});
        end
        if (f[31]) r = -r;
        return r;
    endfunction

    // double -> binary32 with round-to-nearest-even; returns {ovf, bits}
    function automatic logic [32:0] r2f(input real r);
        logic [63:0] d, sig, kept;
        logic [31:0] m;
        int          fexp, sh, ef;
        logic        rb, st, inc;
        d = $realtobits(r);
        if (d[62:52] == 11'h0) return {1'b0, d[63], 31'h0};
        fexp = int'(d[62:52]) - 896;
        sig  = {11'h0, 1'b1, d[51:0]};
        sh   = (fexp < 1) ? 30 - fexp : 29;
        if (fexp >= 255) begin
            m = {d[63], 8'hFF, 23'h0};
        end else if (sh >= 54) begin
            m = {d[63], 31'h0};
        end else begin
            kept  = sig >> sh;
            rb    = sig[sh-1];
            st    = (sig & ((64'h1 << (sh - 1)) - 64'h1)) != 64'h0;
            inc   = rb & (st | kept[0]);
            ef    = (fexp < 1) ? 0 : fexp;
            m     = (32'(ef) << 23) + {9'h0, kept[22:0]} + {31'h0, inc};
            m[31] = d[63];
        end
        return {m[30:23] == 8'hFF, m};
    endfunction

    // Reference sum of two finite operands; returns {ovf, bits}
    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] fa, fb;
        logic [32:0] res;
        fa = a;
        fb = b;
        if (!SUBNORM_EN && fa[30:23] == 8'h00) fa = {fa[31], 31'h0};
        if (!SUBNORM_EN && fb[30:23] == 8'h00) fb = {fb[31], 31'h0};
        res = r2f(f2r(fa) + f2r(fb));
        if (!SUBNORM_EN && res[30:23] == 8'h00) res[30:0] = 31'h0;
        return res;
    endfunction

    task automatic test_reset();
        rstn   = 1'b0;
        bus.x1 = 32'h3F800000;
        bus.x2 = 32'h3F800000;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.y !== 32'h0 || bus.ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: y=%h ovf=%b, expected y=00000000 ovf=0", bus.y, bus.ovf);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] va [3] = '{32'h3F800000, 32'h40400000, 32'h3F800000};
        logic [31:0] vb [3] = '{32'h3F800000, 32'hC0000000, 32'h40000000};
        logic [31:0] vy [3] = '{32'h40000000, 32'h3F800000, 32'h40400000};
        for (int i = 0; i < 3; i++) begin
            bus.x1 = va[i];
            bus.x2 = vb[i];
            if (i == 0) begin
                // Result must not appear before the sampling edge
                #1;
                n_cmp++;
                if (bus.y !== 32'h0) begin
                    n_bad++;
                    $display("FAIL latency_pre_edge: y=%h, expected y=00000000", bus.y);
                end
            end
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.y !== vy[i] || bus.ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL basic[%0d]: y=%h ovf=%b, expected y=%h ovf=0", i, bus.y, bus.ovf, vy[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] va [5] = '{32'h7F7FFFFF, 32'h7F800000, 32'hFF7FFFFF, 32'h7F000000, 32'h7F7FFFFF};
        logic [31:0] vb [5] = '{32'h7F7FFFFF, 32'h3F800000, 32'hFF7FFFFF, 32'h7F000000, 32'h3F800000};
        logic [31:0] vy [5] = '{32'h7F800000, 32'h7F800000, 32'hFF800000, 32'h7F800000, 32'h7F7FFFFF};
        logic        vo [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.x1 = va[i];
            bus.x2 = vb[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.y !== vy[i] || bus.ovf !== vo[i]) begin
                n_bad++;
                $display("FAIL overflow[%0d]: y=%h ovf=%b, expected y=%h ovf=%b", i, bus.y, bus.ovf, vy[i], vo[i]);
            end
        end
    endtask

    task automatic test_zero_signs();
        logic [31:0] va [5] = '{32'h3F800000, 32'hBF800000, 32'h80000000, 32'h00000000, 32'h80000000};
        logic [31:0] vb [5] = '{32'hBF800000, 32'h3F800000, 32'h80000000, 32'h80000000, 32'h00000000};
        logic [31:0] vy [5] = '{32'h00000000, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};
        for (int i = 0; i < 5; i++) begin
            bus.x1 = va[i];
            bus.x2 = vb[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.y !== vy[i] || bus.ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL zero_sign[%0d]: y=%h ovf=%b, expected y=%h ovf=0", i, bus.y, bus.ovf, vy[i]);
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] va [4] = '{32'h4B800000, 32'h4B800001, 32'h4B800000, 32'h3F800000};
        logic [31:0] vb [4] = '{32'h3F800000, 32'h3F800000, 32'h3FC00000, 32'hB3000000};
        logic [31:0] vy [4] = '{32'h4B800000, 32'h4B800002, 32'h4B800001, 32'h3F800000};
        for (int i = 0; i < 4; i++) begin
            bus.x1 = va[i];
            bus.x2 = vb[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.y !== vy[i] || bus.ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL rounding[%0d]: y=%h ovf=%b, expected y=%h ovf=0", i, bus.y, bus.ovf, vy[i]);
            end
        end
    endtask

    task automatic test_subnormal();
        logic [31:0] va [3] = '{32'h00000001, 32'h00800000, 32'h00400000};
        logic [31:0] vb [3] = '{32'h00000001, 32'h80000001, 32'h00400000};
`ifdef FADD_SUBNORMAL_EN
        logic [31:0] vy [3] = '{32'h00000002, 32'h007FFFFF, 32'h00800000};
`else
        logic [31:0] vy [3] = '{32'h00000000, 32'h00800000, 32'h00000000};
`endif
        for (int i = 0; i < 3; i++) begin
            bus.x1 = va[i];
            bus.x2 = vb[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.y !== vy[i] || bus.ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL subnormal[%0d]: y=%h ovf=%b, expected y=%h ovf=0", i, bus.y, bus.ovf, vy[i]);
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] va [6] = '{32'h7F800000, 32'h7F800001, 32'h3F800000,
                                32'h7FC00000, 32'hFF800000, 32'h3F800000};
        logic [31:0] vb [6] = '{32'hFF800000, 32'h3F800000, 32'hFF800005,
                                32'hFF800001, 32'hFF800000, 32'hFF800000};
        logic [31:0] vy [6] = '{32'hFFC00000, 32'h7FC00001, 32'hFFC00005,
                                32'h7FC00000, 32'hFF800000, 32'hFF800000};
        for (int i = 0; i < 6; i++) begin
            bus.x1 = va[i];
            bus.x2 = vb[i];
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.y !== vy[i] || bus.ovf !== 1'b0) begin
                n_bad++;
                $display("FAIL special[%0d]: y=%h ovf=%b, expected y=%h ovf=0", i, bus.y, bus.ovf, vy[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [22:0] corner [7] = '{23'h000000, 23'h000001, 23'h000002, 23'h3C0000,
                                    23'h400000, 23'h5FFFFF, 23'h7FFFFF};
        logic [22:0] ma, mb;
        logic [31:0] a, b;
        logic [32:0] exp_r;
        int          c;
        c = 0;
        for (int ea = 0; ea < 255; ea++) begin
            for (int eb = 0; eb < 255; eb++) begin
                ma = (c % 8 == 7) ? 23'($urandom) : corner[c % 8];
                mb = ((c / 8) % 8 == 7) ? 23'($urandom) : corner[(c / 8) % 8];
                a  = {1'(c / 64), 8'(ea), ma};
                b  = {1'(c / 128), 8'(eb), mb};
                exp_r  = ref_add(a, b);
                bus.x1 = a;
                bus.x2 = b;
                @(posedge clk);
                #1;
                n_cmp++;
                if (bus.y !== exp_r[31:0] || bus.ovf !== exp_r[32]) begin
                    n_bad++;
                    $display("FAIL sweep %h+%h: y=%h ovf=%b, expected y=%h ovf=%b",
                             a, b, bus.y, bus.ovf, exp_r[31:0], exp_r[32]);
                end
                c++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        bus.x1 = 32'h3F800000;
        bus.x2 = 32'h3F800000;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.y !== 32'h40000000) begin
            n_bad++;
            $display("FAIL midreset_pre: y=%h, expected y=40000000", bus.y);
        end
        #2;
        rstn = 1'b0;
        #1;
        n_cmp++;
        if (bus.y !== 32'h0 || bus.ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_async: y=%h ovf=%b, expected y=00000000 ovf=0", bus.y, bus.ovf);
        end
        bus.x1 = 32'h40000000;
        bus.x2 = 32'h3F800000;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.y !== 32'h0 || bus.ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_hold: y=%h ovf=%b, expected y=00000000 ovf=0", bus.y, bus.ovf);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (bus.y !== 32'h40400000 || bus.ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_first: y=%h ovf=%b, expected y=40400000 ovf=0", bus.y, bus.ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_zero_signs();
        test_rounding();
        test_subnormal();
        test_specials();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
